// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunk-serial add/subtract unit.
// Holds the FSM state encoding and the counter-width helper.
package seq_chunk_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A single-chunk build still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Start/busy/done handshake bundle for seq_chunk_adder.
// The master drives the operands; the slave returns the result.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder_chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple adder built from per-bit full adders.
// c_msb is the carry into the top bit, used by the parent for signed overflow.
module chunk_ripple_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands consumed CHUNK bits per clock
// through a registered carry; result and flags hold until the next accepted start.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_chunk_adder_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_r;
    logic [WIDTH-1:0]   sum_shift;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               done_r;
    logic               cout_r;
    logic               ovf_r;
    logic               accept;
    logic               running;
    logic               last;
    logic [CHUNK-1:0]   chunk_s;
    logic               chunk_co;
    logic               chunk_c_msb;

    chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_sh[CHUNK-1:0]),
        .b     (b_sh[CHUNK-1:0]),
        .ci    (carry),
        .s     (chunk_s),
        .co    (chunk_co),
        .c_msb (chunk_c_msb)
    );

    // New chunks enter from the MSB side so the first (lowest) chunk ends up at the bottom.
    if (NCHUNK > 1) begin : g_multi
        assign sum_shift = {chunk_s, sum_r[WIDTH-1:CHUNK]};
    end else begin : g_single
        assign sum_shift = chunk_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        running = (state == RUN);
        accept  = (state == IDLE) && bus.start;
        last    = running && (cnt == LAST);
    end

    // Subtraction is a + ~b + ~borrow, so invert b and the incoming carry at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                a_sh  <= bus.a;
                b_sh  <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.cin ^ bus.sub;
                cnt   <= '0;
                sum_r <= '0;
            end else if (running) begin
                a_sh  <= a_sh >> CHUNK;
                b_sh  <= b_sh >> CHUNK;
                carry <= chunk_co;
                sum_r <= sum_shift;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    done_r <= 1'b1;
                    cout_r <= chunk_co;
                    ovf_r  <= chunk_co ^ chunk_c_msb;
                end
            end
        end
    end

    assign bus.busy = running;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule
